sqrt_control_path: RTL and testbench

- Control FSM for the structural square-root unit. It sequences the datapath through three phases: initialise, iterate/compare, update square.
- Inputs are two datapath status flags, N_i[1] (N2) and N_i[0] (N1).
- Outputs are register-write enables, a mux select, a boot/initialise strobe, the current root bit and a ready flag.
- The FSM is a Moore/Mealy mix: the S1 outputs depend combinationally on N_i.

---
 rtl/sqrt_control_path.sv | 80 ++++++++
 tb/tb_sqrt_control_path.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sqrt_control_path.sv
// ============================================================================
// Module   : sqrt_control_path
// Brief    : Control FSM sequencing the square-root datapath (init/iterate/update).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sqrt_control_path (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] N_i,
    output logic       boot_o,
    output logic       muxes_o,
    output logic       ready_o,
    output logic       wr_root_o,
    output logic       wr_square_o,
    output logic       root_o
);

    typedef enum logic [1:0] {
        S0       = 2'b00,
        S1       = 2'b01,
        S2       = 2'b10,
        S_UNUSED = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;

    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = S1;
            S1:      state_d = (N_i == 2'b00) ? S2 : S1;
            S2:      state_d = S1;
            default: state_d = S0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are decoded straight from state (and N_i in S1) so that both the
    // asynchronous reset and N_i changes within S1 take effect without a clock.
    always_comb begin
        boot_o      = 1'b1;
        muxes_o     = 1'b0;
        wr_root_o   = 1'b1;
        wr_square_o = 1'b1;
        root_o      = 1'b0;
        ready_o     = 1'b1;
        case (state_q)
            S1: begin
                boot_o      = 1'b0;
                muxes_o     = 1'b1;
                wr_square_o = 1'b0;
                wr_root_o   = (N_i == 2'b00);
                ready_o     = (N_i == 2'b00);
                root_o      = (N_i == 2'b10);
            end
            S2: begin
                boot_o      = 1'b0;
                muxes_o     = 1'b0;
                wr_root_o   = 1'b0;
                wr_square_o = 1'b1;
                root_o      = 1'b0;
                ready_o     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_sqrt_control_path.sv
// ============================================================================
// Module   : tb_sqrt_control_path
// Brief    : Directed and randomized self-checking bench for sqrt_control_path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sqrt_control_path;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] N_i = 2'b00;
    logic       boot_o, muxes_o, ready_o, wr_root_o, wr_square_o, root_o;

    int vectors = 0;
    int errors  = 0;
    int phase   = 0;   // 0 = initialise, 1 = iterate/compare, 2 = update square

    sqrt_control_path dut (
        .clk         (clk),
        .rst         (rst),
        .N_i         (N_i),
        .boot_o      (boot_o),
        .muxes_o     (muxes_o),
        .ready_o     (ready_o),
        .wr_root_o   (wr_root_o),
        .wr_square_o (wr_square_o),
        .root_o      (root_o)
    );

    // Expected outputs packed as {boot, muxes, wr_root, wr_square, root, ready}.
    function automatic logic [5:0] expected(input int ph, input logic [1:0] n);
        if (ph == 1) begin
            case (n)
                2'b00:   return 6'b011001;
                2'b10:   return 6'b010010;
                default: return 6'b010000;
            endcase
        end else if (ph == 2) begin
            return 6'b000101;
        end
        return 6'b101101;
    endfunction

    function automatic int next_phase(input int ph, input logic [1:0] n);
        if (ph == 1) return (n == 2'b00) ? 2 : 1;
        return 1;
    endfunction

    task automatic check(input string tag);
        logic [5:0] obs;
        logic [5:0] exp;
        #1;
        obs = {boot_o, muxes_o, wr_root_o, wr_square_o, root_o, ready_o};
        exp = expected(phase, N_i);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: phase=%0d N=%b observed %b expected %b", tag, phase, N_i, obs, exp);
        end
    endtask

    task automatic tick();
        int nxt;
        nxt = next_phase(phase, N_i);
        clk = 1'b1;
        if (rst) phase = nxt;
        #5;
        clk = 1'b0;
        #5;
    endtask

    initial begin
        // Reset held, then released, with the clock idle: S0 for every N_i.
        for (int i = 0; i < 4; i++) begin
            N_i = 2'(i);
            check("reset_held");
        end
        rst = 1'b1;
        #2;
        for (int i = 0; i < 4; i++) begin
            N_i = 2'(i);
            check("s0_idle");
        end

        // S0 -> S1 with N=11, then sweep N within S1.
        N_i = 2'b11;
        tick();
        for (int i = 0; i < 4; i++) begin
            N_i = 2'(i);
            check("s1_sweep");
        end

        // S1 with N=00 -> S2, sweep N within S2.
        N_i = 2'b00;
        tick();
        for (int i = 0; i < 4; i++) begin
            N_i = 2'(i);
            check("s2_sweep");
        end

        // S2 -> S1 regardless of N, observe with N=00.
        N_i = 2'b10;
        tick();
        N_i = 2'b00;
        check("s2_to_s1");

        // S1 holds while N=01 across an edge.
        N_i = 2'b01;
        tick();
        check("s1_hold");
        tick();
        check("s1_hold2");

        // Into S2, then asynchronous reset between edges.
        N_i = 2'b00;
        tick();
        check("s2_again");
        #2;
        rst   = 1'b0;
        phase = 0;
        check("async_rst");
        N_i = 2'b10;
        check("async_rst_n");
        rst = 1'b1;
        #2;
        check("rst_release");
        tick();
        check("post_rst_edge");

        // Randomized walk with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            N_i = 2'($urandom_range(0, 3));
            check("rand_out");
            if ($urandom_range(0, 2) != 0) begin
                tick();
                check("rand_edge");
            end
            if ($urandom_range(0, 24) == 0) begin
                #1;
                rst   = 1'b0;
                phase = 0;
                check("rand_rst");
                rst = 1'b1;
                #2;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
